wb8_arbiter2: RTL and testbench
===============================

WB8_ARBITER2 -- requirements
Module: wb8_arbiter2

Interface
REQ-001 Parameter ADR_WIDTH, default 1, slave address width.
REQ-002 Parameter TIMEOUT, default 15, max BUSY cycles without slave ack before forced termination (range 2..255).
REQ-003 Reset I_reset, synchronous, active-high; clock I_wb_clk.
REQ-004 I_wb_clk  in  1  clock; I_reset  in  1  synchronous active-high reset.
REQ-005 I_m0_stb / I_m0_we  in  1 each  master 0 request strobe / write enable.
REQ-006 I_m0_adr  in  ADR_WIDTH  master 0 address; I_m0_dat  in  8  master 0 write data.
REQ-007 O_m0_ack  out  1  master 0 ack; O_m0_dat  out  8  master 0 read data.
REQ-008 I_m1_stb, I_m1_we, I_m1_adr, I_m1_dat, O_m1_ack, O_m1_dat: identical widths and meaning, master 1.
REQ-009 O_s_stb / O_s_we  out  1 each; O_s_adr  out  ADR_WIDTH; O_s_dat  out  8; slave-side request.
REQ-010 I_s_ack  in  1; I_s_dat  in  8; slave response.
REQ-011 O_timeout  out  1  one-cycle pulse on forced termination.

Function
REQ-012 States: IDLE, BUSY; registers: grant (1 bit), last (1 bit), timer (8 bits).
REQ-013 IDLE: O_s_stb=0, O_m0_ack=O_m1_ack=0, I_s_ack ignored.
REQ-014 IDLE, exactly one stb high: grant<=that master, ->BUSY, timer<=0.
REQ-015 IDLE, both stb high: grant<=!last (round-robin), ->BUSY.
REQ-016 BUSY: O_s_stb=granted stb, O_s_we/O_s_adr/O_s_dat = granted master's signals; non-granted master's outputs unchanged on slave side.
REQ-017 BUSY: O_mX_ack = I_s_ack when grant==X, else 0; O_mX_dat = I_s_dat when grant==X and I_s_ack, else 0x00.
REQ-018 BUSY, I_s_ack=1: ->IDLE, last<=grant.
REQ-019 Latency: stb in IDLE cycle t -> O_s_stb at t+1; slave ack at t+k routed same cycle; >=1 IDLE cycle between consecutive slave transactions.
REQ-020 BUSY, granted stb drops without ack (abort): ->IDLE, no ack, last<=grant.
REQ-021 BUSY, timer==TIMEOUT-1 and no I_s_ack: O_mX_ack=1 to granted master, O_mX_dat=0xFF, O_timeout=1, O_s_stb=0, ->IDLE, last<=grant.
REQ-022 timer increments each BUSY cycle without ack, saturates, cleared on BUSY entry.
REQ-023 Ack and timeout same cycle: ack wins, O_timeout=0, slave data returned.
REQ-024 Non-granted master held with O_mX_ack=0 indefinitely until granted.

Reset
REQ-025 I_reset=1 at posedge: state<=IDLE, grant<=0, last<=1 (m0 wins first tie), timer<=0; takes priority mid-transaction, no ack issued.
REQ-026 All outputs 0 in the cycle after reset.

Structure
REQ-027 Package wb8_arb_pkg: state encoding (IDLE=0, BUSY=1), TIMEOUT_DEFAULT=15, TIMEOUT_DATA=8'hFF.
REQ-028 Sub-module wb8_arb_timer (clear, enable, limit compare, saturating count) instantiated once.

Verification
REQ-029 m0 write adr 0 data 0x5A, slave acks 1 cycle after stb -> O_s_stb high t+1, O_m0_ack high t+2, O_m1_ack never high.
REQ-030 m0 and m1 stb together after reset -> m0 granted first, m1 granted next after one IDLE cycle; repeat -> m0/m1 alternate.
REQ-031 m1 read, slave I_s_dat=0x3C with ack -> O_m1_dat=0x3C during ack, O_m0_dat=0x00.
REQ-032 Slave never acks, TIMEOUT=15 -> O_m0_ack and O_timeout high exactly one cycle, 15 cycles after grant, O_m0_dat=0xFF.
REQ-033 I_reset asserted in BUSY -> next cycle IDLE, O_s_stb=0, no master ack; next tie grants m0.
REQ-034 Granted master drops stb mid-BUSY -> return to IDLE, no ack, waiting master granted next.

Source files
------------

// File: rtl/wb8_arb_pkg.sv
// wb8_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
//   arb_state_e   - arbiter FSM state encoding (IDLE=0, BUSY=1)
//   TIMER_W       - width of the BUSY watchdog counter
//   DATA_W        - Wishbone data width
//   TIMEOUT_*     - default watchdog limit and data returned on forced termination
package wb8_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;
  localparam int unsigned TIMER_W         = 8;
  localparam int unsigned DATA_W          = 8;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/wb8_arb_timer.sv
// wb8_arb_timer: saturating watchdog counter for a BUSY slave transaction.
//   i_clk, i_reset - clock, synchronous active-high reset
//   i_clear        - zero the count (held while the arbiter is idle)
//   i_enable       - count one cycle (BUSY without slave ack)
//   i_limit        - compare value
//   o_at_limit     - count equals i_limit
module wb8_arb_timer
  import wb8_arb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_at_limit
);

  logic [TIMER_W-1:0] r_count;

  // Count stops at all-ones so a very long stall cannot wrap back under the limit.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {TIMER_W{1'b1}})) begin
      r_count <= r_count + TIMER_W'(1);
    end
  end

  assign o_at_limit = (r_count == i_limit);

endmodule

// File: rtl/wb8_arbiter2.sv
// wb8_arbiter2: round-robin arbiter giving two 8-bit Wishbone masters access to one slave.
//   I_wb_clk, I_reset             - clock, synchronous active-high reset
//   I_mX_stb/we/adr/dat           - master X request (X = 0, 1)
//   O_mX_ack/dat                  - master X response (ack and read data routed same cycle)
//   O_s_stb/we/adr/dat            - request forwarded to the slave
//   I_s_ack/dat                   - slave response
//   O_timeout                     - one-cycle pulse when a stalled transaction is force-terminated
// Outputs are decoded from the registered state so the slave ack reaches the master in the
// same cycle; an IDLE cycle always separates consecutive slave transactions.
module wb8_arbiter2
  import wb8_arb_pkg::*;
#(
  parameter int unsigned ADR_WIDTH = 1,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 I_wb_clk,
  input  logic                 I_reset,
  input  logic                 I_m0_stb,
  input  logic                 I_m0_we,
  input  logic [ADR_WIDTH-1:0] I_m0_adr,
  input  logic [DATA_W-1:0]    I_m0_dat,
  output logic                 O_m0_ack,
  output logic [DATA_W-1:0]    O_m0_dat,
  input  logic                 I_m1_stb,
  input  logic                 I_m1_we,
  input  logic [ADR_WIDTH-1:0] I_m1_adr,
  input  logic [DATA_W-1:0]    I_m1_dat,
  output logic                 O_m1_ack,
  output logic [DATA_W-1:0]    O_m1_dat,
  output logic                 O_s_stb,
  output logic                 O_s_we,
  output logic [ADR_WIDTH-1:0] O_s_adr,
  output logic [DATA_W-1:0]    O_s_dat,
  input  logic                 I_s_ack,
  input  logic [DATA_W-1:0]    I_s_dat,
  output logic                 O_timeout
);

  localparam logic [TIMER_W-1:0] LP_LIMIT = TIMER_W'(TIMEOUT - 1);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_grant;
  logic       w_grant_next;
  logic       r_last;
  logic       w_last_next;

  logic                 w_g_stb;
  logic                 w_g_we;
  logic [ADR_WIDTH-1:0] w_g_adr;
  logic [DATA_W-1:0]    w_g_dat;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_at_limit;

  // Request of the currently granted master.
  assign w_g_stb = r_grant ? I_m1_stb : I_m0_stb;
  assign w_g_we  = r_grant ? I_m1_we  : I_m0_we;
  assign w_g_adr = r_grant ? I_m1_adr : I_m0_adr;
  assign w_g_dat = r_grant ? I_m1_dat : I_m0_dat;

  // Held at zero while idle, so every BUSY entry starts from a cleared count.
  assign w_timer_clear = (r_state == ST_IDLE);
  assign w_timer_en    = (r_state == ST_BUSY) && !I_s_ack;

  wb8_arb_timer u_timer (
    .i_clk      (I_wb_clk),
    .i_reset    (I_reset),
    .i_clear    (w_timer_clear),
    .i_enable   (w_timer_en),
    .i_limit    (LP_LIMIT),
    .o_at_limit (w_at_limit)
  );

  // State, grant and round-robin history registers.
  always_ff @(posedge I_wb_clk) begin
    if (I_reset) begin
      r_state <= ST_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    O_s_stb      = 1'b0;
    O_s_we       = 1'b0;
    O_s_adr      = '0;
    O_s_dat      = '0;
    O_m0_ack     = 1'b0;
    O_m0_dat     = '0;
    O_m1_ack     = 1'b0;
    O_m1_dat     = '0;
    O_timeout    = 1'b0;

    // Reset wins over an in-flight transaction: nothing is acknowledged in that cycle.
    if (!I_reset) begin
      case (r_state)
        ST_IDLE: begin
          if (I_m0_stb && I_m1_stb) begin
            w_grant_next = !r_last;
            w_state_next = ST_BUSY;
          end else if (I_m0_stb) begin
            w_grant_next = 1'b0;
            w_state_next = ST_BUSY;
          end else if (I_m1_stb) begin
            w_grant_next = 1'b1;
            w_state_next = ST_BUSY;
          end
        end

        ST_BUSY: begin
          O_s_stb = w_g_stb;
          O_s_we  = w_g_we;
          O_s_adr = w_g_adr;
          O_s_dat = w_g_dat;
          if (I_s_ack) begin
            // Slave ack beats a coincident timeout.
            if (r_grant) begin
              O_m1_ack = 1'b1;
              O_m1_dat = I_s_dat;
            end else begin
              O_m0_ack = 1'b1;
              O_m0_dat = I_s_dat;
            end
            w_state_next = ST_IDLE;
            w_last_next  = r_grant;
          end else if (!w_g_stb) begin
            // Master abandoned the cycle: release silently.
            w_state_next = ST_IDLE;
            w_last_next  = r_grant;
          end else if (w_at_limit) begin
            O_s_stb   = 1'b0;
            O_timeout = 1'b1;
            if (r_grant) begin
              O_m1_ack = 1'b1;
              O_m1_dat = TIMEOUT_DATA;
            end else begin
              O_m0_ack = 1'b1;
              O_m0_dat = TIMEOUT_DATA;
            end
            w_state_next = ST_IDLE;
            w_last_next  = r_grant;
          end
        end

        default: w_state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb8_arbiter2.sv
// tb_wb8_arbiter2: randomized scoreboard bench for wb8_arbiter2.
// The driver plans whole rounds (who requests, how the slave answers), predicts the service
// order and the cycle of every master ack, and queues those predictions; a negedge monitor
// pops and compares whenever a master ack appears.
module tb_wb8_arbiter2;

  localparam int AW    = 2;
  localparam int TO    = 15;
  localparam int M_ACK = 0;
  localparam int M_TO  = 1;
  localparam int M_ABT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ms_stb[2];
  logic          ms_we[2];
  logic [AW-1:0] ms_adr[2];
  logic [7:0]    ms_dat[2];
  logic          s_ack;
  logic [7:0]    s_dat;

  logic          m0_ack, m1_ack, s_stb, s_we, timeout;
  logic [7:0]    m0_dat, m1_dat, s_dat_o;
  logic [AW-1:0] s_adr;

  wb8_arbiter2 #(.ADR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .I_wb_clk (clk),
    .I_reset  (rst),
    .I_m0_stb (ms_stb[0]),
    .I_m0_we  (ms_we[0]),
    .I_m0_adr (ms_adr[0]),
    .I_m0_dat (ms_dat[0]),
    .O_m0_ack (m0_ack),
    .O_m0_dat (m0_dat),
    .I_m1_stb (ms_stb[1]),
    .I_m1_we  (ms_we[1]),
    .I_m1_adr (ms_adr[1]),
    .I_m1_dat (ms_dat[1]),
    .O_m1_ack (m1_ack),
    .O_m1_dat (m1_dat),
    .O_s_stb  (s_stb),
    .O_s_we   (s_we),
    .O_s_adr  (s_adr),
    .O_s_dat  (s_dat_o),
    .I_s_ack  (s_ack),
    .I_s_dat  (s_dat),
    .O_timeout(timeout)
  );

  typedef struct {
    bit            we;
    logic [AW-1:0] adr;
    logic [7:0]    wdat;
    logic [7:0]    rdat;
    int            mode;
    int            len;
  } tx_t;

  typedef struct {
    bit         m;
    logic [7:0] dat;
    bit         to;
    int         cyc;
  } exp_t;

  tx_t  plan[2];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   mdl_last = 1'b1;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic set_plan(input int m, input bit we, input logic [AW-1:0] adr,
                          input logic [7:0] wdat, input logic [7:0] rdat,
                          input int mode, input int len);
    plan[m].we   = we;
    plan[m].adr  = adr;
    plan[m].wdat = wdat;
    plan[m].rdat = rdat;
    plan[m].mode = mode;
    plan[m].len  = len;
  endtask

  task automatic gen_plan(input int m);
    int sel;
    int mode;
    int len;
    sel = int'($urandom_range(0, 9));
    if (sel < 6) begin
      mode = M_ACK;
      len  = int'($urandom_range(1, TO));
    end else if (sel < 8) begin
      mode = M_TO;
      len  = TO;
    end else begin
      mode = M_ABT;
      len  = int'($urandom_range(1, TO - 1));
    end
    set_plan(m, 1'($urandom), AW'($urandom), 8'($urandom), 8'($urandom), mode, len);
  endtask

  // One arbitration round: the requesting masters raise stb together while the arbiter is idle.
  task automatic run_round(input bit r0, input bit r1);
    int   order[$];
    int   t;
    int   m;
    bit   exp_stb;
    exp_t e;
    if (r0 && r1) begin
      m = mdl_last ? 0 : 1;
      order.push_back(m);
      order.push_back(1 - m);
    end else if (r0) begin
      order.push_back(0);
    end else begin
      order.push_back(1);
    end
    mdl_last = (order[order.size() - 1] == 1);

    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if ((i == 0) ? r0 : r1) begin
        ms_stb[i] = 1'b1;
        ms_we[i]  = plan[i].we;
        ms_adr[i] = plan[i].adr;
        ms_dat[i] = plan[i].wdat;
      end else begin
        ms_stb[i] = 1'b0;
        ms_we[i]  = 1'($urandom);
        ms_adr[i] = AW'($urandom);
        ms_dat[i] = 8'($urandom);
      end
    end
    s_ack = 1'b0;
    s_dat = 8'($urandom);

    // Predicted ack cycles: each grant follows one idle cycle.
    t = cyc;
    foreach (order[i]) begin
      m = order[i];
      t = t + plan[m].len;
      if (plan[m].mode != M_ABT) begin
        e.m   = (m == 1);
        e.dat = (plan[m].mode == M_ACK) ? plan[m].rdat : 8'hFF;
        e.to  = (plan[m].mode == M_TO);
        e.cyc = t;
        exp_q.push_back(e);
      end
      t = t + 1;
    end

    @(negedge clk);
    chk("idle_gap", 64'(s_stb), 64'd0);

    foreach (order[i]) begin
      m = order[i];
      for (int k = 1; k <= plan[m].len; k++) begin
        @(posedge clk); #1;
        s_ack = 1'b0;
        s_dat = 8'($urandom);
        if (plan[m].mode == M_ACK && k == plan[m].len) begin
          s_ack = 1'b1;
          s_dat = plan[m].rdat;
        end
        if (plan[m].mode == M_ABT && k == plan[m].len) ms_stb[m] = 1'b0;
        @(negedge clk);
        exp_stb = (plan[m].mode == M_ACK) || (k < plan[m].len);
        chk("s_stb", 64'(s_stb), 64'(exp_stb));
        if (exp_stb)
          chk("s_payload", 64'({s_we, s_adr, s_dat_o}),
              64'({plan[m].we, plan[m].adr, plan[m].wdat}));
      end
      @(posedge clk); #1;
      s_ack     = 1'b0;
      ms_stb[m] = 1'b0;
      @(negedge clk);
      chk("idle_gap", 64'(s_stb), 64'd0);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (m0_ack || m1_ack) begin
        chk("ack_exclusive", 64'(m0_ack & m1_ack), 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_ack: m0=%0b m1=%0b at cycle %0d", m0_ack, m1_ack, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("ack_event {m,dat,timeout,cycle}",
              64'({m1_ack, (m1_ack ? m1_dat : m0_dat), timeout, cyc}),
              64'({e.m, e.dat, e.to, e.cyc}));
        end
      end else begin
        chk("timeout_without_ack", 64'(timeout), 64'd0);
        if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
          n_checks++;
          n_err++;
          $display("FAIL missing_ack: got none expected m%0d at cycle %0d", exp_q[0].m, exp_q[0].cyc);
          e = exp_q.pop_front();
        end
      end
      if (!m0_ack) chk("m0_dat_idle", 64'(m0_dat), 64'd0);
      if (!m1_ack) chk("m1_dat_idle", 64'(m1_dat), 64'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int r;
    rst = 1'b1;
    s_ack = 1'b0;
    s_dat = 8'h00;
    for (int i = 0; i < 2; i++) begin
      ms_stb[i] = 1'b0;
      ms_we[i]  = 1'b0;
      ms_adr[i] = '0;
      ms_dat[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 64'({s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, m0_dat, m1_dat, timeout}), 64'd0);
    mdl_last = 1'b1;
    mon_en   = 1'b1;

    // Ties after reset: m0 first, then alternation.
    set_plan(0, 1'b1, 2'd1, 8'h11, 8'hA1, M_ACK, 3);
    set_plan(1, 1'b0, 2'd2, 8'h22, 8'hB2, M_ACK, 2);
    run_round(1'b1, 1'b1);
    set_plan(0, 1'b0, 2'd3, 8'h33, 8'hC3, M_ACK, 1);
    set_plan(1, 1'b1, 2'd0, 8'h44, 8'hD4, M_ACK, 4);
    run_round(1'b1, 1'b1);

    // m0 write, slave acks one cycle after seeing stb.
    set_plan(0, 1'b1, 2'd0, 8'h5A, 8'h96, M_ACK, 2);
    run_round(1'b1, 1'b0);

    // Reset in the middle of a BUSY transaction.
    set_plan(0, 1'b0, 2'd2, 8'h66, 8'h00, M_ACK, 5);
    @(posedge clk); #1;
    ms_stb[0] = 1'b1;
    ms_we[0]  = plan[0].we;
    ms_adr[0] = plan[0].adr;
    ms_dat[0] = plan[0].wdat;
    @(negedge clk);
    chk("rst_pre_idle", 64'(s_stb), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pre_busy", 64'(s_stb), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ms_stb[0] = 1'b0;
    s_ack = 1'b1;
    s_dat = 8'h77;
    @(negedge clk);
    chk("post_reset_outputs", 64'({s_stb, s_we, s_adr, s_dat_o, m0_ack, m1_ack, m0_dat, m1_dat, timeout}), 64'd0);
    @(posedge clk); #1;
    s_ack = 1'b0;
    mdl_last = 1'b1;
    set_plan(0, 1'b1, 2'd1, 8'h81, 8'h18, M_ACK, 2);
    set_plan(1, 1'b1, 2'd3, 8'h82, 8'h28, M_ACK, 3);
    run_round(1'b1, 1'b1);

    // m1 read returning 0x3C.
    set_plan(1, 1'b0, 2'd1, 8'h00, 8'h3C, M_ACK, 3);
    run_round(1'b0, 1'b1);

    // Slave never answers: forced termination.
    set_plan(0, 1'b0, 2'd2, 8'h00, 8'h00, M_TO, TO);
    run_round(1'b1, 1'b0);

    // Ack and timeout in the same cycle.
    set_plan(1, 1'b0, 2'd0, 8'h00, 8'hE7, M_ACK, TO);
    run_round(1'b0, 1'b1);

    // Granted master aborts, waiting master is served next.
    first = mdl_last ? 0 : 1;
    set_plan(first, 1'b1, 2'd3, 8'h9C, 8'h00, M_ABT, 4);
    set_plan(1 - first, 1'b0, 2'd1, 8'h00, 8'h4B, M_ACK, 2);
    run_round(1'b1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(1, 3));
      gen_plan(0);
      gen_plan(1);
      run_round(r[0], r[1]);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
